fetch_line_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decoder.
- Issues 64-byte line reads on the system bus and collects the 8 × 64-bit response beats into a 128-byte circular byte buffer.
- Presents a 15-byte window plus its RIP to the decoder; the decoder returns how many bytes it consumed each cycle.
- Handles entry start-up, mid-line start addresses, and redirects (flush plus refetch).

---
 rtl/fetch_line_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_line_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_unit.sv
// Instruction-fetch front end: 64-byte line requests into a 128-byte circular buffer, 15-byte decode window.
// Optional counters perf_lines / perf_stall are built only when FETCH_PERF_EN is defined.
module fetch_line_unit #(
    parameter int               TAG_W      = 13,
    parameter logic [TAG_W-1:0] READ_TAG   = 13'h1100,
    parameter int               REQ_THRESH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       entry,
    input  logic              redirect,
    input  logic [63:0]       redirect_rip,
    output logic              reqcyc,
    output logic [63:0]       req,
    output logic [TAG_W-1:0]  reqtag,
    input  logic              reqack,
    input  logic              respcyc,
    input  logic [63:0]       resp,
    output logic              respack,
    output logic [119:0]      out_bytes,
    output logic [63:0]       out_rip,
    output logic              out_valid,
    input  logic [3:0]        consume_len,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_lines,
    output logic [31:0]       perf_stall,
`endif
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0]  THRESH    = 8'(REQ_THRESH);
    localparam logic [63:0] LINE_MASK = ~64'h3f;

    state_t      r_state;
    state_t      w_next_state;
    logic [63:0] r_req;
    logic [63:0] r_out_rip;
    logic [6:0]  r_wr_ptr;
    logic [6:0]  r_rd_ptr;
    logic        r_drop;
    logic [2:0]  r_skip_beats;
    logic [2:0]  r_beat_cnt;
    logic        r_started;
    logic [63:0] r_buf [16];

    logic [6:0]   w_occ_raw;
    logic [7:0]   w_occ;
    logic         w_out_valid;
    logic         w_beat;
    logic         w_last_beat;
    logic         w_keep;
    logic         w_consume;
    logic [6:0]   w_addr [15];
    logic [119:0] w_window;

    // Until the first kept beat lands, rd_ptr may sit ahead of wr_ptr, so the
    // raw pointer difference is meaningless and occupancy is forced to zero.
    assign w_occ_raw   = r_wr_ptr - r_rd_ptr;
    assign w_occ       = r_started ? {1'b0, w_occ_raw} : 8'd0;
    assign w_out_valid = (w_occ >= 8'd15);

    assign w_beat      = (r_state == S_RESP) && respcyc;
    assign w_last_beat = w_beat && (r_beat_cnt == 3'd7);
    assign w_keep      = w_beat && !r_drop && (r_beat_cnt >= r_skip_beats) && !redirect;
    assign w_consume   = w_out_valid && (consume_len != 4'd0) && !redirect;

    // Bus handshake: reqcyc/req are held stable from the first REQ cycle until the
    // edge where reqack is seen; every respcyc beat is acknowledged in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (redirect || (w_occ <= THRESH)) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (reqack) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (w_last_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        reqcyc      = (r_state == S_REQ);
        req         = r_req;
        reqtag      = READ_TAG;
        respack     = respcyc;
        out_bytes   = w_window;
        out_rip     = r_out_rip;
        out_valid   = w_out_valid;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req        <= entry & LINE_MASK;
            r_out_rip    <= entry;
            r_wr_ptr     <= 7'd0;
            r_rd_ptr     <= {4'd0, entry[2:0]};
            r_drop       <= 1'b0;
            r_skip_beats <= entry[5:3];
            r_beat_cnt   <= 3'd0;
            r_started    <= 1'b0;
        end else begin
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
            if (redirect) begin
                r_wr_ptr     <= 7'd0;
                r_rd_ptr     <= {4'd0, redirect_rip[2:0]};
                r_out_rip    <= redirect_rip;
                r_started    <= 1'b0;
                r_req        <= redirect_rip & LINE_MASK;
                r_skip_beats <= redirect_rip[5:3];
                // A line already accepted by the bus must be drained before refetching.
                r_drop       <= ((r_state == S_RESP) && !w_last_beat) ||
                                ((r_state == S_REQ) && reqack);
            end else begin
                if (w_keep) begin
                    r_wr_ptr  <= r_wr_ptr + 7'd8;
                    r_started <= 1'b1;
                end
                if (w_consume) begin
                    r_rd_ptr  <= r_rd_ptr + {3'd0, consume_len};
                    r_out_rip <= r_out_rip + 64'(consume_len);
                end
                if (w_last_beat) begin
                    if (r_drop) begin
                        r_drop <= 1'b0;
                    end else begin
                        r_req        <= r_req + 64'd64;
                        r_skip_beats <= 3'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_buf[r_wr_ptr[6:3]] <= resp;
        end
    end

    always_comb begin
        for (int i = 0; i < 15; i++) begin
            w_addr[i] = r_rd_ptr + 7'(i);
            w_window[8*i +: 8] = r_buf[w_addr[i][6:3]][{w_addr[i][2:0], 3'b000} +: 8];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_lines;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_lines <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_last_beat && !r_drop && !redirect && (r_perf_lines != '1)) begin
                r_perf_lines <= r_perf_lines + 32'd1;
            end
            if (!w_out_valid && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_lines = r_perf_lines;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_line_unit.sv
// Directed bench for fetch_line_unit: reset/entry table, threshold, streaming wrap, redirect, mid-line reset.
module tb_fetch_line_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect;
    logic [63:0]  redirect_rip;
    logic         reqcyc;
    logic [63:0]  req;
    logic [12:0]  reqtag;
    logic         reqack;
    logic         respcyc;
    logic [63:0]  resp;
    logic         respack;
    logic [119:0] out_bytes;
    logic [63:0]  out_rip;
    logic         out_valid;
    logic [3:0]   consume_len;
    logic [1:0]   o_dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_lines;
    logic [31:0]  perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int bench_stall = 0;
    bit stall_en = 1'b0;

    typedef struct {
        logic [63:0] entry;
        logic [63:0] exp_req;
        int          valid_beat;
    } vec_t;
    vec_t vecs [5];

    fetch_line_unit dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redirect     (redirect),
        .redirect_rip (redirect_rip),
        .reqcyc       (reqcyc),
        .req          (req),
        .reqtag       (reqtag),
        .reqack       (reqack),
        .respcyc      (respcyc),
        .resp         (resp),
        .respack      (respack),
        .out_bytes    (out_bytes),
        .out_rip      (out_rip),
        .out_valid    (out_valid),
        .consume_len  (consume_len),
`ifdef FETCH_PERF_EN
        .perf_lines   (perf_lines),
        .perf_stall   (perf_stall),
`endif
        .o_dbg_state  (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h3c;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(a + 64'(k));
        return w;
    endfunction

    function automatic logic [119:0] exp_window(input logic [63:0] rip);
        logic [119:0] w;
        for (int i = 0; i < 15; i++) w[8*i +: 8] = mem_byte(rip + 64'(i));
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        if (stall_en && reset && !out_valid) bench_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [63:0] e);
        entry = e;
        redirect = 1'b0;
        redirect_rip = 64'd0;
        reqack = 1'b0;
        respcyc = 1'b0;
        resp = 64'd0;
        consume_len = 4'd0;
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic wait_req(input logic [63:0] exp_addr, input int ack_delay, input bit do_ack,
                            input string name);
        int n = 0;
        while (reqcyc !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check({name, "_seen"}, reqcyc, 1);
        check(name, req, exp_addr);
        check({name, "_tag"}, reqtag, 13'h1100);
        if (do_ack) begin
            for (int k = 0; k < ack_delay; k++) begin
                step();
                check({name, "_hold"}, {reqcyc, req}, {1'b1, exp_addr});
            end
            reqack = 1'b1;
            step();
            reqack = 1'b0;
            check({name, "_deassert"}, reqcyc, 0);
        end
    endtask

    task automatic send_beat(input logic [63:0] addr);
        respcyc = 1'b1;
        resp = mem_word(addr);
        check("respack", respack, 1);
        step();
        respcyc = 1'b0;
    endtask

    // Decoder eats 15 bytes whenever the bench's own occupancy model says the window is valid.
    task automatic run_stream(input logic [63:0] base, input int nlines, input string name);
        logic [63:0] exp_rip = base;
        logic [63:0] line = base;
        int exp_occ = 0;
        int ph = 0;
        int beat = 0;
        int done = 0;
        bit vld;
        consume_len = 4'd15;
        for (int cyc = 0; cyc < 40 * nlines && done < nlines; cyc++) begin
            reqack = 1'b0;
            respcyc = 1'b0;
            if (ph == 0 && reqcyc) begin
                check({name, "_req"}, req, line);
                reqack = 1'b1;
                ph = 1;
            end else if (ph == 2) begin
                respcyc = 1'b1;
                resp = mem_word(line + 64'(8 * beat));
            end
            vld = (exp_occ >= 15);
            check({name, "_valid"}, out_valid, vld);
            check({name, "_rip"}, out_rip, exp_rip);
            if (vld) check({name, "_bytes"}, out_bytes, exp_window(exp_rip));
            step();
            if (ph == 1) begin
                ph = 2;
            end else if (respcyc) begin
                exp_occ += 8;
                beat++;
                if (beat == 8) begin
                    beat = 0;
                    ph = 0;
                    line += 64;
                    done++;
                end
            end
            if (vld) begin
                exp_occ -= 15;
                exp_rip += 15;
            end
        end
        reqack = 1'b0;
        respcyc = 1'b0;
        check({name, "_lines"}, done, nlines);
    endtask

    initial begin
        vecs[0] = '{64'h1000, 64'h1000, 1};
        vecs[1] = '{64'h1009, 64'h1000, 2};
        vecs[2] = '{64'h1020, 64'h1000, 5};
        vecs[3] = '{64'h102B, 64'h1000, 7};
        vecs[4] = '{64'h1037, 64'h1000, 8};

        // Entry table: reset values, skipped beats, first valid beat, next line address.
        for (int i = 0; i < 5; i++) begin
            apply_reset(vecs[i].entry);
            check("rst_reqcyc", reqcyc, 0);
            check("rst_req", req, vecs[i].exp_req);
            check("rst_reqtag", reqtag, 13'h1100);
            check("rst_valid", out_valid, 0);
            check("rst_rip", out_rip, vecs[i].entry);
            check("rst_state", o_dbg_state, 0);
            reset = 1'b1;
            wait_req(vecs[i].exp_req, i % 3, 1'b1, "tbl_req");
            for (int b = 0; b < 8; b++) begin
                send_beat(vecs[i].exp_req + 64'(8 * b));
                check("tbl_valid", out_valid, (b >= vecs[i].valid_beat));
                check("tbl_reqcyc_resp", reqcyc, 0);
            end
            check("tbl_rip", out_rip, vecs[i].entry);
            if (vecs[i].valid_beat < 8) check("tbl_bytes", out_bytes, exp_window(vecs[i].entry));
            wait_req(vecs[i].exp_req + 64'd64, 0, 1'b0, "tbl_next_req");
        end

        // Request threshold: occupancy 64 requests at once, 118 waits until it drains to 58.
        apply_reset(64'h5000);
        reset = 1'b1;
        wait_req(64'h5000, 0, 1'b1, "thr_req0");
        for (int b = 0; b < 8; b++) send_beat(64'h5000 + 64'(8 * b));
        check("thr_idle_after_line", reqcyc, 0);
        step();
        check("thr_req_at_64", reqcyc, 1);
        wait_req(64'h5040, 0, 1'b1, "thr_req1");
        for (int b = 0; b < 8; b++) begin
            consume_len = (b == 0) ? 4'd10 : 4'd0;
            send_beat(64'h5040 + 64'(8 * b));
        end
        for (int k = 0; k < 5; k++) begin
            consume_len = 4'd15;
            step();
            check("thr_wait_drain", reqcyc, (k == 4));
        end
        consume_len = 4'd0;
        check("thr_req2", req, 64'h5080);
        check("thr_rip", out_rip, 64'h5055);
        check("thr_bytes", out_bytes, exp_window(64'h5055));

        // Streaming four lines: window continuity across the 127 -> 0 wrap.
        apply_reset(64'h2000);
        reset = 1'b1;
        run_stream(64'h2000, 4, "strm");
        consume_len = 4'd0;

        // Redirect during beat 3: remainder drained, refetch of the new line.
        apply_reset(64'h2000);
        reset = 1'b1;
        wait_req(64'h2000, 0, 1'b1, "rdr_req0");
        for (int b = 0; b < 3; b++) send_beat(64'h2000 + 64'(8 * b));
        check("rdr_valid_before", out_valid, 1);
        redirect = 1'b1;
        redirect_rip = 64'h3010;
        send_beat(64'h2018);
        redirect = 1'b0;
        check("rdr_valid_after", out_valid, 0);
        check("rdr_rip_after", out_rip, 64'h3010);
        for (int b = 4; b < 8; b++) begin
            send_beat(64'h2000 + 64'(8 * b));
            check("rdr_drop_valid", out_valid, 0);
            check("rdr_drop_reqcyc", reqcyc, 0);
        end
        wait_req(64'h3000, 2, 1'b1, "rdr_req1");
        for (int b = 0; b < 8; b++) begin
            send_beat(64'h3000 + 64'(8 * b));
            check("rdr_fill_valid", out_valid, (b >= 3));
        end
        check("rdr_rip", out_rip, 64'h3010);
        check("rdr_bytes", out_bytes, exp_window(64'h3010));

        // Reset pulsed low mid-line: stale beats acked and ignored, fetch restarts at new entry.
        apply_reset(64'h2000);
        reset = 1'b1;
        wait_req(64'h2000, 1, 1'b1, "mrst_req0");
        for (int b = 0; b < 3; b++) send_beat(64'h2000 + 64'(8 * b));
        entry = 64'h4000;
        respcyc = 1'b1;
        resp = mem_word(64'h2018);
        reset = 1'b0;
        #1;
        check("mrst_reqcyc", reqcyc, 0);
        check("mrst_req", req, 64'h4000);
        check("mrst_valid", out_valid, 0);
        check("mrst_rip", out_rip, 64'h4000);
        check("mrst_respack", respack, 1);
        step();
        resp = mem_word(64'h2020);
        step();
        reset = 1'b1;
        for (int b = 5; b < 7; b++) begin
            resp = mem_word(64'h2000 + 64'(8 * b));
            check("mrst_stale_respack", respack, 1);
            step();
            check("mrst_stale_valid", out_valid, 0);
        end
        respcyc = 1'b0;
        wait_req(64'h4000, 0, 1'b1, "mrst_req1");
        for (int b = 0; b < 8; b++) begin
            send_beat(64'h4000 + 64'(8 * b));
            check("mrst_fill_valid", out_valid, (b >= 1));
        end
        check("mrst_rip_final", out_rip, 64'h4000);
        check("mrst_bytes", out_bytes, exp_window(64'h4000));

`ifdef FETCH_PERF_EN
        // Three counted lines, one dropped line, stall cycles tallied independently.
        apply_reset(64'h6000);
        check("perf_rst_lines", perf_lines, 0);
        check("perf_rst_stall", perf_stall, 0);
        bench_stall = 0;
        stall_en = 1'b1;
        reset = 1'b1;
        run_stream(64'h6000, 3, "perf");
        wait_req(64'h60C0, 0, 1'b1, "perf_req3");
        send_beat(64'h60C0);
        redirect = 1'b1;
        redirect_rip = 64'h7000;
        send_beat(64'h60C8);
        redirect = 1'b0;
        for (int b = 2; b < 8; b++) send_beat(64'h60C0 + 64'(8 * b));
        step();
        check("perf_lines", perf_lines, 3);
        check("perf_stall", perf_stall, bench_stall);
        stall_en = 1'b0;
        consume_len = 4'd0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
